// File: rtl/op_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | op_pkg: mode and y-source codes shared by the operational path       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package op_pkg;

  typedef enum logic [1:0] {
    REG_OFF     = 2'd0,
    REG_ENUM    = 2'd1,
    REG_COUNT   = 2'd2,
    REG_REFRESH = 2'd3
  } regime_e;

  typedef enum logic [1:0] {
    YSEL_HOLD = 2'd0,
    YSEL_INC  = 2'd1,
    YSEL_ROT  = 2'd2,
    YSEL_X    = 2'd3
  } ysel_e;

endpackage : op_pkg
`default_nettype wire

// File: rtl/step_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_accumulator: step register s with add/sub and zero detect       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module step_accumulator #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_en,
  input  logic         s_zero,
  input  logic         s_add,
  input  logic [1:0]   s_step,
  output logic [W-1:0] s,
  output logic         s_is_zero
);

  logic [W-1:0] r_s;
  logic [W-1:0] w_base;
  logic [W-1:0] w_step;
  logic [W-1:0] w_next;

  always_comb begin
    w_base = s_zero ? '0 : r_s;
    w_step = {{(W-2){1'b0}}, s_step};
    w_next = s_add ? (w_base + w_step) : (w_base - w_step);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '0;
    end else if (s_en) begin
      r_s <= w_next;
    end
  end

  assign s = r_s;
  // Zero flag comes straight from the register so the controller sees it with no latency.
  assign s_is_zero = (r_s == '0);

endmodule : step_accumulator
`default_nettype wire

// File: rtl/op_path.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | op_path: operational path (s, y, x registers, display, event count)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module op_path
  import op_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    regime,
  input  logic          active,
  input  logic [1:0]    y_select_next,
  input  logic [1:0]    s_step,
  input  logic          y_en,
  input  logic          s_en,
  input  logic          y_store_x,
  input  logic          s_add,
  input  logic          s_zero,
  output logic          s_is_zero,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] evt_count
);

  logic [W-1:0]  w_s;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_dout;
  logic [CW-1:0] r_evt;
  logic [W-1:0]  w_y_next;
  logic          w_evt_inc;

  step_accumulator #(.W(W)) u_step_accumulator (
    .clk       (clk),
    .rst       (rst),
    .s_en      (s_en),
    .s_zero    (s_zero),
    .s_add     (s_add),
    .s_step    (s_step),
    .s         (w_s),
    .s_is_zero (s_is_zero)
  );

  always_comb begin
    w_y_next = r_y;
    case (y_select_next)
      YSEL_HOLD: w_y_next = r_y;
      YSEL_INC:  w_y_next = r_y + 1'b1;
      YSEL_ROT:  w_y_next = {r_y[W-2:0], r_y[W-1]};
      YSEL_X:    w_y_next = r_x;
      default:   w_y_next = r_y;
    endcase
  end

  assign w_evt_inc = y_en && (y_select_next == YSEL_INC) && (regime == REG_COUNT);

  // x and y both sample pre-edge values, so store+load with YSEL_X swaps them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= '0;
      r_x    <= '0;
      r_dout <= '0;
      r_evt  <= '0;
    end else begin
      if (y_en) begin
        r_y <= w_y_next;
      end
      if (y_store_x) begin
        r_x <= r_y;
      end
      r_dout <= active ? w_s : r_y;
      if (w_evt_inc && (r_evt != {CW{1'b1}})) begin
        r_evt <= r_evt + 1'b1;
      end
    end
  end

  assign dout      = r_dout;
  assign evt_count = r_evt;

endmodule : op_path
`default_nettype wire

// File: tb/tb_op_path.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_op_path: directed + random checks against an arithmetic model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_op_path;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] regime;
  logic       active;
  logic [1:0] y_select_next;
  logic [1:0] s_step;
  logic       y_en, s_en, y_store_x, s_add, s_zero;
  logic       s_is_zero;
  logic [3:0] dout;
  logic [7:0] evt_count;

  int n_vec = 0;
  int n_err = 0;

  // reference state: plain integers, values in 0..15 / 0..255
  int m_s, m_y, m_x, m_dout, m_evt;

  op_path #(.W(4), .CW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .regime        (regime),
    .active        (active),
    .y_select_next (y_select_next),
    .s_step        (s_step),
    .y_en          (y_en),
    .s_en          (s_en),
    .y_store_x     (y_store_x),
    .s_add         (s_add),
    .s_zero        (s_zero),
    .s_is_zero     (s_is_zero),
    .dout          (dout),
    .evt_count     (evt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_y = 0; m_x = 0; m_dout = 0; m_evt = 0;
  endtask

  // One clock edge: predict from pre-edge state, then compare visible outputs.
  task automatic tick();
    int ns, ny, nx, nd, ne, base, st;
    st = int'(s_step);
    ns = m_s; ny = m_y; nx = m_x; ne = m_evt;
    if (s_en) begin
      base = s_zero ? 0 : m_s;
      ns = s_add ? (base + st) % 16 : (base - st + 16) % 16;
    end
    if (y_en) begin
      case (int'(y_select_next))
        0: ny = m_y;
        1: ny = (m_y + 1) % 16;
        2: ny = (m_y * 2) % 16 + m_y / 8;
        default: ny = m_x;
      endcase
    end
    if (y_store_x) nx = m_y;
    nd = active ? m_s : m_y;
    if (y_en && y_select_next == 2'd1 && regime == 2'd2 && m_evt < 255) ne = m_evt + 1;
    @(posedge clk);
    m_s = ns; m_y = ny; m_x = nx; m_dout = nd; m_evt = ne;
    #1;
    chk("dout", dout, m_dout);
    chk("s_is_zero", s_is_zero, (m_s == 0) ? 1 : 0);
    chk("evt_count", evt_count, m_evt);
  endtask

  task automatic idle();
    s_en = 0; y_en = 0; y_store_x = 0; s_zero = 0; s_add = 0; s_step = 0;
    y_select_next = 0;
  endtask

  task automatic cmd_s(input logic z, input logic a, input logic [1:0] st);
    idle(); s_en = 1; s_zero = z; s_add = a; s_step = st;
    tick();
  endtask

  task automatic cmd_y(input logic [1:0] sel, input logic store, input logic [1:0] rg);
    idle(); y_en = 1; y_select_next = sel; y_store_x = store; regime = rg;
    tick();
  endtask

  task automatic peek_s(input int exp);
    idle(); active = 1; tick();
    chk("s_value", dout, exp);
  endtask

  task automatic peek_y(input int exp);
    idle(); active = 0; tick();
    chk("y_value", dout, exp);
  endtask

  initial begin
    rst = 1; regime = 0; active = 0; idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset mid-operation
    cmd_s(1, 1, 2'd3);
    cmd_s(0, 1, 2'd2);
    for (int i = 0; i < 9; i++) cmd_y(2'd1, 0, 2'd2);
    peek_s(5);
    peek_y(9);
    chk("evt_before_rst", evt_count, 9);
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_dout", dout, 0);
    chk("rst_evt", evt_count, 0);
    chk("rst_zero", s_is_zero, 1);
    #1 rst = 0;
    peek_s(0);
    peek_y(0);

    // enumeration
    cmd_s(1, 1, 2'd1); peek_s(1);
    cmd_s(0, 1, 2'd2); peek_s(3);
    cmd_s(0, 1, 2'd2); peek_s(5);
    cmd_s(0, 1, 2'd2); peek_s(7);
    cmd_s(1, 1, 2'd1); peek_s(1);

    // decrement to zero, then wrap
    cmd_s(0, 0, 2'd1);
    chk("zero_at_0", s_is_zero, 1);
    cmd_s(0, 0, 2'd2);
    chk("zero_after_wrap", s_is_zero, 0);
    peek_s(14);

    // count mode: bring y to 15 outside count mode first
    for (int i = 0; i < 15; i++) cmd_y(2'd1, 0, 2'd1);
    chk("evt_enum_mode", evt_count, 0);
    cmd_y(2'd1, 0, 2'd2);
    chk("evt_first", evt_count, 1);
    peek_y(0);
    for (int i = 0; i < 300; i++) cmd_y(2'd1, 0, 2'd2);
    chk("evt_saturated", evt_count, 255);
    cmd_y(2'd1, 0, 2'd1);
    chk("evt_enum_hold", evt_count, 255);

    // refresh: y to 6, snapshot, rotate, reload, swap
    while (m_y != 6) cmd_y(2'd1, 0, 2'd0);
    cmd_y(2'd0, 1, 2'd3); peek_y(6);
    cmd_y(2'd2, 0, 2'd3); peek_y(12);
    cmd_y(2'd3, 0, 2'd3); peek_y(6);
    cmd_y(2'd2, 0, 2'd3); peek_y(12);
    cmd_y(2'd3, 1, 2'd3); peek_y(6);
    cmd_y(2'd3, 0, 2'd3); peek_y(12);

    // display path
    cmd_s(1, 1, 2'd3);
    while (m_y != 10) cmd_y(2'd1, 0, 2'd0);
    idle(); active = 1; tick();
    chk("disp_s", dout, 3);
    active = 0; tick();
    chk("disp_y", dout, 10);
    active = 1; #2;
    chk("disp_no_comb", dout, 10);

    // random traffic, occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      regime = 2'($urandom); active = 1'($urandom);
      y_select_next = 2'($urandom); s_step = 2'($urandom);
      y_en = 1'($urandom); s_en = 1'($urandom); y_store_x = 1'($urandom);
      s_add = 1'($urandom); s_zero = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1;
        #1 model_reset();
        chk("rnd_rst_zero", s_is_zero, 1);
        chk("rnd_rst_dout", dout, 0);
        #1 rst = 0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_op_path
`default_nettype wire
